// File: rtl/squash_pkg.sv
// squash_pkg: shared FSM state type and default sequence-number width
package squash_pkg;
  localparam int SEQ_W = 5;
  typedef enum logic {IDLE, PEND} state_e;
endpackage

// File: rtl/squash_redirect_ctrl_if.sv
// squash_redirect_ctrl_if: squash requests, commit, redirect and flush signals
interface squash_redirect_ctrl_if
  import squash_pkg::*;
#(
  parameter int P_NUM_ARB      = 2,
  parameter int P_SEQ_NUM_BITS = SEQ_W
);
  logic [P_NUM_ARB-1:0]                     arb_val;
  logic [P_NUM_ARB-1:0][P_SEQ_NUM_BITS-1:0] arb_seq_num;
  logic [P_NUM_ARB-1:0][31:0]               arb_target;
  logic                                     commit_val;
  logic                                     redir_val;
  logic                                     redir_rdy;
  logic [31:0]                              redir_target;
  logic [P_SEQ_NUM_BITS-1:0]                redir_seq_num;
  logic                                     squash_val;
  logic [P_SEQ_NUM_BITS-1:0]                squash_seq_num;
  modport master (
    output arb_val, arb_seq_num, arb_target, commit_val, redir_rdy,
    input  redir_val, redir_target, redir_seq_num, squash_val, squash_seq_num
  );
  modport slave (
    input  arb_val, arb_seq_num, arb_target, commit_val, redir_rdy,
    output redir_val, redir_target, redir_seq_num, squash_val, squash_seq_num
  );
endinterface

// File: rtl/squash_age_cmp.sv
// squash_age_cmp: true when i_a is strictly older than i_b, ages taken relative to i_head
module squash_age_cmp
  import squash_pkg::*;
#(
  parameter int P_W = SEQ_W
) (
  input  logic [P_W-1:0] i_head,
  input  logic [P_W-1:0] i_a,
  input  logic [P_W-1:0] i_b,
  output logic           o_older
);
  logic [P_W-1:0] w_age_a;
  logic [P_W-1:0] w_age_b;
  assign w_age_a = i_a - i_head;
  assign w_age_b = i_b - i_head;
  assign o_older = w_age_a < w_age_b;
endmodule

// File: rtl/squash_redirect_ctrl.sv
// squash_redirect_ctrl: picks the oldest squash, holds the redirect until fetch takes it, pulses a backend flush (stats via SQUASH_REDIRECT_STATS_EN)
module squash_redirect_ctrl
  import squash_pkg::*;
#(
  parameter int P_NUM_ARB      = 2,
  parameter int P_SEQ_NUM_BITS = SEQ_W
) (
  input  logic                   clk,
  input  logic                   rst,
  squash_redirect_ctrl_if.slave  bus
`ifdef SQUASH_REDIRECT_STATS_EN
  ,
  output logic [31:0]            stat_squash_cnt,
  output logic [31:0]            stat_replace_cnt
`endif
);
  localparam int W = P_SEQ_NUM_BITS;
  state_e         r_state;
  state_e         w_state_nxt;
  logic [W-1:0]   r_head;
  logic [W-1:0]   r_seq;
  logic [31:0]    r_tgt;
  logic           r_sq;
  logic           w_bval [P_NUM_ARB];
  logic [W-1:0]   w_bseq [P_NUM_ARB];
  logic [31:0]    w_btgt [P_NUM_ARB];
  logic           w_any;
  logic [W-1:0]   w_win_seq;
  logic [31:0]    w_win_tgt;
  logic           w_win_older;
  logic           w_pend;
  logic           w_hs;
  logic           w_cap;
  logic           w_repl;
  // Linear selection chain: a later requester only wins when strictly older, so ties keep the lower index
  for (genvar i = 0; i < P_NUM_ARB; i++) begin : g_sel
    if (i == 0) begin : g_first
      assign w_bval[0] = bus.arb_val[0];
      assign w_bseq[0] = bus.arb_seq_num[0];
      assign w_btgt[0] = bus.arb_target[0];
    end else begin : g_rest
      logic w_older;
      logic w_take;
      squash_age_cmp #(.P_W(W)) u_cmp (
        .i_head (r_head),
        .i_a    (bus.arb_seq_num[i]),
        .i_b    (w_bseq[i-1]),
        .o_older(w_older)
      );
      assign w_take    = bus.arb_val[i] & (~w_bval[i-1] | w_older);
      assign w_bval[i] = w_bval[i-1] | bus.arb_val[i];
      assign w_bseq[i] = w_take ? bus.arb_seq_num[i] : w_bseq[i-1];
      assign w_btgt[i] = w_take ? bus.arb_target[i] : w_btgt[i-1];
    end
  end
  assign w_any     = w_bval[P_NUM_ARB-1];
  assign w_win_seq = w_bseq[P_NUM_ARB-1];
  assign w_win_tgt = w_btgt[P_NUM_ARB-1];
  squash_age_cmp #(.P_W(W)) u_held_cmp (
    .i_head (r_head),
    .i_a    (w_win_seq),
    .i_b    (r_seq),
    .o_older(w_win_older)
  );
  assign w_pend = r_state == PEND;
  assign w_hs   = w_pend & bus.redir_rdy;
  assign w_cap  = w_any & (~w_pend | w_hs | w_win_older);
  assign w_repl = w_cap & w_pend & ~w_hs;
  // Next state: any capture keeps or enters PEND, an accepted redirect with no capture returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (w_cap) w_state_nxt = PEND;
    else if (w_hs) w_state_nxt = IDLE;
  end
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // Head of the in-flight window advances once per commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_head <= '0;
    else if (bus.commit_val) r_head <= r_head + 1'b1;
  end
  // Held squash and the one-cycle flush pulse that accompanies every capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq <= '0;
      r_tgt <= '0;
      r_sq  <= 1'b0;
    end else begin
      r_sq <= w_cap;
      if (w_cap) begin
        r_seq <= w_win_seq;
        r_tgt <= w_win_tgt;
      end
    end
  end
  assign bus.redir_val      = w_pend;
  assign bus.redir_target   = r_tgt;
  assign bus.redir_seq_num  = r_seq;
  assign bus.squash_val     = r_sq;
  assign bus.squash_seq_num = r_sq ? r_seq : '0;
`ifdef SQUASH_REDIRECT_STATS_EN
  logic [31:0] r_sq_cnt;
  logic [31:0] r_rep_cnt;
  // Saturating counts of captures and of captures that displaced a still-pending redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sq_cnt  <= '0;
      r_rep_cnt <= '0;
    end else begin
      if (w_cap && !(&r_sq_cnt)) r_sq_cnt <= r_sq_cnt + 1'b1;
      if (w_repl && !(&r_rep_cnt)) r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end
  assign stat_squash_cnt  = r_sq_cnt;
  assign stat_replace_cnt = r_rep_cnt;
`endif
`ifndef SYNTHESIS
  // A squashed instruction must never commit while its redirect is pending
  a_no_squashed_commit: assert property (@(posedge clk) disable iff (!rst)
    !(w_pend && bus.commit_val && r_head == r_seq + 1'b1));
`endif
endmodule
